seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a common-anode multi-digit seven-segment display. It scans `DIGITS` 4-bit character codes onto shared segment lines. It adds two features over the fixed four-digit anode scanner: per-slot ghost-suppression dead-time and 16-level PWM brightness. New content is double-buffered and committed only at frame boundaries, so a displayed frame never tears. The block sits between the numeric/formatting logic and the board pins.

---
 rtl/seg_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot dead-time,
// 16-level PWM brightness and frame-synchronous double-buffered content.
//
// Phase FSM (one pass per digit slot, k = slot counter):
//   state    | meaning
//   PH_GUARD | k < GUARD, dead-time, all anodes off, segments blank
//   PH_ON    | GUARD <= k < GUARD + b*STEP, current digit lit
//   PH_OFF   | remainder of slot, dark
module seg_scan_driver #(
    parameter int DIGITS = 4,
    parameter int GUARD  = 2,
    parameter int STEP   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   chars,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [3:0]            bright,
    input  logic                  load,
    output logic                  pending,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            display,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int SLOT = GUARD + 15 * STEP;
    localparam int KW   = $clog2(SLOT + 1);
    localparam int DW   = $clog2(DIGITS);

    typedef enum logic [1:0] {PH_GUARD, PH_ON, PH_OFF} phase_t;

    logic                r_run;
    logic [KW-1:0]       r_k;
    logic [DW-1:0]       r_dig;
    phase_t              r_phase;
    logic [4*DIGITS-1:0] r_stg_chars, r_act_chars;
    logic [DIGITS-1:0]   r_stg_dp, r_act_dp;
    logic [3:0]          r_stg_bright, r_act_bright;
    logic                r_pending;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_display;
    logic                r_dp;
    logic                r_frame_done;

    logic                w_wrap;
    logic [KW-1:0]       w_k_nxt;
    logic [DW-1:0]       w_dig_nxt;
    logic [4*DIGITS-1:0] w_act_chars_nxt;
    logic [DIGITS-1:0]   w_act_dp_nxt;
    logic [3:0]          w_act_bright_nxt;
    logic [KW-1:0]       w_on_end;
    phase_t              w_phase_nxt;
    logic [3:0]          w_char;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_an_on;
    logic                w_fd_nxt;
    logic                w_pend_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:  glyph = 7'b0000001;
            4'd1:  glyph = 7'b1001111;
            4'd2:  glyph = 7'b0010010;
            4'd3:  glyph = 7'b0000110;
            4'd4:  glyph = 7'b1001100;
            4'd5:  glyph = 7'b0100100;
            4'd6:  glyph = 7'b0100000;
            4'd7:  glyph = 7'b0001111;
            4'd8:  glyph = 7'b0000000;
            4'd9:  glyph = 7'b0000100;
            4'd10: glyph = 7'b1111110;
            4'd11: glyph = 7'b0111000;
            4'd12: glyph = 7'b1111111;
            4'd13: glyph = 7'b0110000;
            4'd14: glyph = 7'b1111010;
            default: glyph = 7'b1001000;
        endcase
    endfunction

    // Outputs are registered from next-cycle counters so they line up with k.
    assign w_wrap    = (r_k == KW'(SLOT - 1));
    assign w_k_nxt   = !r_run ? '0 : (w_wrap ? '0 : r_k + KW'(1));
    assign w_dig_nxt = !r_run ? '0 :
                       (w_wrap ? ((r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + DW'(1)) : r_dig);

    // A load coinciding with frame_done bypasses staging straight to active.
    always_comb begin
        w_act_chars_nxt  = r_act_chars;
        w_act_dp_nxt     = r_act_dp;
        w_act_bright_nxt = r_act_bright;
        if (r_frame_done && load) begin
            w_act_chars_nxt  = chars;
            w_act_dp_nxt     = dp_in;
            w_act_bright_nxt = bright;
        end else if (r_frame_done && r_pending) begin
            w_act_chars_nxt  = r_stg_chars;
            w_act_dp_nxt     = r_stg_dp;
            w_act_bright_nxt = r_stg_bright;
        end
    end

    assign w_on_end = KW'(GUARD) + KW'(w_act_bright_nxt) * KW'(STEP);

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_k_nxt < KW'(GUARD)) begin
            w_phase_nxt = PH_GUARD;
        end else begin
            case (r_phase)
                PH_GUARD: w_phase_nxt = (w_k_nxt < w_on_end) ? PH_ON : PH_OFF;
                PH_ON:    w_phase_nxt = (w_k_nxt < w_on_end) ? PH_ON : PH_OFF;
                default:  w_phase_nxt = PH_OFF;
            endcase
        end
    end

    assign w_char     = w_act_chars_nxt[{w_dig_nxt, 2'b00} +: 4];
    assign w_glyph    = glyph(w_char);
    assign w_an_on    = ~(DIGITS'(1) << w_dig_nxt);
    assign w_fd_nxt   = (w_k_nxt == KW'(SLOT - 1)) && (w_dig_nxt == DW'(DIGITS - 1));
    assign w_pend_nxt = load ? !r_frame_done : (r_frame_done ? 1'b0 : r_pending);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run        <= 1'b0;
            r_k          <= '0;
            r_dig        <= '0;
            r_phase      <= PH_GUARD;
            r_stg_chars  <= {DIGITS{4'd12}};
            r_stg_dp     <= '0;
            r_stg_bright <= 4'd0;
            r_act_chars  <= {DIGITS{4'd12}};
            r_act_dp     <= '0;
            r_act_bright <= 4'd15;
            r_pending    <= 1'b0;
            r_an         <= '1;
            r_display    <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_k          <= w_k_nxt;
            r_dig        <= w_dig_nxt;
            r_phase      <= w_phase_nxt;
            if (load) begin
                r_stg_chars  <= chars;
                r_stg_dp     <= dp_in;
                r_stg_bright <= bright;
            end
            r_act_chars  <= w_act_chars_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_act_bright <= w_act_bright_nxt;
            r_pending    <= w_pend_nxt;
            r_frame_done <= w_fd_nxt;
            case (w_phase_nxt)
                PH_ON: begin
                    r_an      <= w_an_on;
                    r_display <= w_glyph;
                    r_dp      <= ~w_act_dp_nxt[w_dig_nxt];
                end
                default: begin
                    r_an      <= '1;
                    r_display <= 7'h7F;
                    r_dp      <= 1'b1;
                end
            endcase
        end
    end

    assign pending    = r_pending;
    assign an         = r_an;
    assign display    = r_display;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues one expected summary per
// digit slot, a negedge monitor summarises each observed slot and compares.
module tb_seg_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] lit;
        logic [7:0] first;
        logic [6:0] disp;
        logic       dpo;
        logic       fd;
        logic       err;
    } rec_t;

    logic        clk;
    logic        reset;
    logic [15:0] chars;
    logic [3:0]  dp_in;
    logic [3:0]  bright;
    logic        load;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  display;
    logic        dp;
    logic        frame_done;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   mc      = 0;
    bit   mon_on  = 0;
    rec_t exp_q[$];
    rec_t cur;

    logic [6:0] GL [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b1111110, 7'b0111000,
                            7'b1111111, 7'b0110000, 7'b1111010, 7'b1001000};

    seg_scan_driver #(.DIGITS(4), .GUARD(2), .STEP(4)) dut (
        .clk(clk), .reset(reset), .chars(chars), .dp_in(dp_in), .bright(bright),
        .load(load), .pending(pending), .an(an), .display(display), .dp(dp),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_load(input logic [15:0] ch, input logic [3:0] dpv, input logic [3:0] b);
        chars  = ch;
        dp_in  = dpv;
        bright = b;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        cyc    = 0;
        mon_on = 1'b1;
    endtask

    // Expected slot summaries: lit for b*STEP cycles starting at k = GUARD.
    task automatic push_frame(input logic [15:0] ch, input logic [3:0] dpv,
                              input int b, input int ndig);
        rec_t r;
        for (int d = 0; d < ndig; d++) begin
            r.an    = (b != 0) ? ~(4'b0001 << d) : 4'hF;
            r.lit   = 8'(b * 4);
            r.first = (b != 0) ? 8'd2 : 8'hFF;
            r.disp  = (b != 0) ? GL[ch[4*d +: 4]] : 7'h7F;
            r.dpo   = (b != 0) ? ~dpv[d] : 1'b1;
            r.fd    = (d == 3);
            r.err   = 1'b0;
            exp_q.push_back(r);
        end
    endtask

    initial begin : monitor
        int   kk;
        rec_t e;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                mc = 0;
            end else begin
                kk = mc % 62;
                if (kk == 0) cur = '{an: 4'hF, lit: 8'd0, first: 8'hFF, disp: 7'h7F,
                                     dpo: 1'b1, fd: 1'b0, err: 1'b0};
                if (an != 4'hF) begin
                    if ($countones(~an) != 1) cur.err = 1'b1;
                    if (cur.lit == 0) begin
                        cur.first = 8'(kk);
                        cur.an    = an;
                        cur.disp  = display;
                        cur.dpo   = dp;
                    end else if (an != cur.an || display != cur.disp || dp != cur.dpo) begin
                        cur.err = 1'b1;
                    end
                    cur.lit = cur.lit + 8'd1;
                end else if (display != 7'h7F || dp != 1'b1) begin
                    cur.err = 1'b1;
                end
                if (frame_done) begin
                    if (kk == 61) cur.fd = 1'b1;
                    else cur.err = 1'b1;
                end
                if (kk == 61) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL slot_unexpected: slot at cycle %0d has no expectation", mc);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur == e) n_pass++;
                        else $display("FAIL slot@%0d: got an=%b lit=%0d first=%0d seg=%b dp=%b fd=%b err=%b expected an=%b lit=%0d first=%0d seg=%b dp=%b fd=%b err=%b",
                                      mc, cur.an, cur.lit, cur.first, cur.disp, cur.dpo, cur.fd, cur.err,
                                      e.an, e.lit, e.first, e.disp, e.dpo, e.fd, e.err);
                    end
                end
                mc++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset  = 1'b0;
        chars  = 16'h0;
        dp_in  = 4'h0;
        bright = 4'h0;
        load   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_outputs", {an, display, dp, frame_done, pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        release_reset();

        push_frame(16'hCCCC, 4'h0, 15, 4);   // frame 0: reset contents
        push_frame(16'hA194, 4'h0, 15, 4);   // frame 1: -194
        push_frame(16'h1234, 4'h5, 5, 4);    // frame 2: brightness 5
        push_frame(16'hCCCC, 4'h0, 0, 4);    // frame 3: dark
        push_frame(16'hBBBB, 4'h0, 15, 4);   // frame 4: FFFF only
        push_frame(16'hDEEF, 4'h8, 10, 2);   // frame 5: up to the reset

        chk("cycle0_outputs", {an, display, dp, frame_done, pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        goto(2);
        do_load(16'hA194, 4'h0, 4'd15);
        chk("pending_after_load", pending, 1'b1);
        goto(247);
        chk("pending_before_commit", {pending, frame_done}, {1'b1, 1'b1});
        step();
        chk("pending_after_commit", {pending, frame_done}, {1'b0, 1'b0});

        goto(300);
        do_load(16'h1234, 4'h5, 4'd5);
        goto(600);
        do_load(16'hCCCC, 4'h0, 4'd0);
        goto(800);
        do_load(16'hCC10, 4'h0, 4'd15);
        chk("pending_first_of_two", pending, 1'b1);
        goto(900);
        do_load(16'hBBBB, 4'h0, 4'd15);

        goto(1239);
        chk("fd_cycle_before_load", {pending, frame_done}, {1'b0, 1'b1});
        do_load(16'hDEEF, 4'h8, 4'd10);
        chk("pending_after_fd_load", pending, 1'b0);
        step();
        chk("pending_stays_low", pending, 1'b0);

        goto(1390);
        do_load(16'h1234, 4'h0, 4'd7);
        chk("pending_before_reset", pending, 1'b1);
        goto(1394);
        chk("lit_before_reset", an, 4'b1011);
        mon_on = 1'b0;
        reset  = 1'b0;
        #1;
        chk("async_reset_outputs", {an, display, dp, frame_done, pending}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        chk("held_reset_outputs", {an, display, dp}, {4'hF, 7'h7F, 1'b1});
        release_reset();
        push_frame(16'hCCCC, 4'h0, 15, 4);
        push_frame(16'hCCCC, 4'h0, 15, 4);
        goto(250);
        chk("staging_discarded", pending, 1'b0);
        goto(496);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
